// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-way traffic light monitor.
package traffic_pkg;

    // Light codes as driven by the light controller; anything else is invalid.
    localparam logic [2:0] LightGreen  = 3'd1;
    localparam logic [2:0] LightYellow = 3'd2;
    localparam logic [2:0] LightRed    = 3'd3;

    // Phase codes: even = green of a direction, odd = its yellow handover.
    localparam logic [2:0] PhaseEGrn = 3'd0;
    localparam logic [2:0] PhaseEYel = 3'd1;
    localparam logic [2:0] PhaseSGrn = 3'd2;
    localparam logic [2:0] PhaseSYel = 3'd3;
    localparam logic [2:0] PhaseWGrn = 3'd4;
    localparam logic [2:0] PhaseWYel = 3'd5;
    localparam logic [2:0] PhaseNGrn = 3'd6;
    localparam logic [2:0] PhaseNYel = 3'd7;

    typedef enum logic [2:0] {
        FaultNone       = 3'd0,
        FaultIllegal    = 3'd1,
        FaultSequence   = 3'd2,
        FaultShortDwell = 3'd3,
        FaultOverstay   = 3'd4
    } fault_code_e;

    localparam logic [3:0] GREEN_CYCLES  = 4'd8;
    localparam logic [3:0] YELLOW_CYCLES = 4'd5;
    localparam logic [3:0] DwellMax      = 4'd15;

    typedef enum logic [1:0] {
        StSync  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } state_e;

    // Expected dwell of a phase: yellow phases are the odd codes.
    function automatic logic [3:0] required_dwell(input logic [2:0] phase);
        return phase[0] ? YELLOW_CYCLES : GREEN_CYCLES;
    endfunction

endpackage

// File: rtl/traffic_pattern_decode.sv
// Combinational decode of the four light codes into {legal, phase}.
module traffic_pattern_decode (
    input  logic [2:0] east_i,
    input  logic [2:0] south_i,
    input  logic [2:0] west_i,
    input  logic [2:0] north_i,
    output logic       legal_o,
    output logic [2:0] phase_o
);
    import traffic_pkg::*;

    // Per-colour direction masks, bit 0 = east, going clockwise.
    logic [3:0] is_g;
    logic [3:0] is_y;
    logic [3:0] is_r;

    assign is_g = {north_i == LightGreen,  west_i == LightGreen,
                   south_i == LightGreen,  east_i == LightGreen};
    assign is_y = {north_i == LightYellow, west_i == LightYellow,
                   south_i == LightYellow, east_i == LightYellow};
    assign is_r = {north_i == LightRed,    west_i == LightRed,
                   south_i == LightRed,    east_i == LightRed};

    // Match against the eight legal masks; at most one can hit.
    always_comb begin
        legal_o = 1'b0;
        phase_o = PhaseEGrn;
        for (int d = 0; d < 4; d++) begin
            if (is_g == (4'b0001 << d) && is_r == ~(4'b0001 << d)) begin
                legal_o = 1'b1;
                phase_o = 3'(2 * d);
            end
            if (is_y == ((4'b0001 << d) | (4'b0001 << ((d + 1) % 4))) &&
                is_r == ~((4'b0001 << d) | (4'b0001 << ((d + 1) % 4)))) begin
                legal_o = 1'b1;
                phase_o = 3'(2 * d + 1);
            end
        end
    end

endmodule

// File: rtl/traffic_monitor.sv
// Four-way traffic light monitor: checks light patterns, phase order and,
// with TRAFFIC_MON_TIMING_CHECK_EN defined, per-phase dwell times.
module traffic_monitor (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] east_i,
    input  logic [2:0] south_i,
    input  logic [2:0] west_i,
    input  logic [2:0] north_i,
    input  logic       clr_i,
    output logic       fault_o,
    output logic [2:0] fault_code_o,
    output logic [2:0] phase_o,
    output logic       phase_valid_o,
    output logic       flash_o
);
    import traffic_pkg::*;

    state_e      state_q;
    logic        fault_q;
    fault_code_e code_q;
    logic [2:0]  phase_q;
    logic        valid_q;
    logic        flash_q;
    logic [1:0]  flash_cnt_q;

`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    logic [3:0]  dwell_q;
    // Set while the current phase was entered mid-way, so its length is unknown.
    logic        skip_q;
`endif

    logic        dec_legal;
    logic [2:0]  dec_phase;
    logic        changed;
    logic        in_sequence;
    fault_code_e fault_code_d;

    traffic_pattern_decode u_decode (
        .east_i  (east_i),
        .south_i (south_i),
        .west_i  (west_i),
        .north_i (north_i),
        .legal_o (dec_legal),
        .phase_o (dec_phase)
    );

    assign changed     = (dec_phase != phase_q);
    assign in_sequence = (dec_phase == phase_q + 3'd1);

    // Highest-priority fault for the current sample while tracking.
    always_comb begin
        fault_code_d = FaultNone;
        if (!dec_legal) begin
            fault_code_d = FaultIllegal;
        end else if (changed && !in_sequence) begin
            fault_code_d = FaultSequence;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
        end else if (!skip_q && changed && dwell_q < required_dwell(phase_q)) begin
            fault_code_d = FaultShortDwell;
        end else if (!skip_q && !changed && dwell_q == required_dwell(phase_q)) begin
            fault_code_d = FaultOverstay;
`endif
        end
    end

    // Monitor FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StSync;
            fault_q     <= 1'b0;
            code_q      <= FaultNone;
            phase_q     <= PhaseEGrn;
            valid_q     <= 1'b0;
            flash_q     <= 1'b0;
            flash_cnt_q <= 2'd0;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
            dwell_q     <= 4'd0;
            skip_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StSync: begin
                    if (dec_legal) begin
                        state_q <= StTrack;
                        phase_q <= dec_phase;
                        valid_q <= 1'b1;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
                        dwell_q <= 4'd1;
                        skip_q  <= 1'b1;
`endif
                    end
                end
                StTrack: begin
                    if (fault_code_d != FaultNone) begin
                        state_q     <= StFault;
                        fault_q     <= 1'b1;
                        code_q      <= fault_code_d;
                        valid_q     <= 1'b0;
                        flash_q     <= 1'b1;
                        flash_cnt_q <= 2'd0;
                    end else if (changed) begin
                        phase_q <= dec_phase;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
                        dwell_q <= 4'd1;
                        skip_q  <= 1'b0;
                    end else if (dwell_q != DwellMax) begin
                        dwell_q <= dwell_q + 4'd1;
`endif
                    end
                end
                StFault: begin
                    if (clr_i) begin
                        state_q     <= StSync;
                        fault_q     <= 1'b0;
                        code_q      <= FaultNone;
                        flash_q     <= 1'b0;
                        flash_cnt_q <= 2'd0;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
                        dwell_q     <= 4'd0;
                        skip_q      <= 1'b0;
`endif
                    end else begin
                        // Beacon holds each level for four cycles.
                        flash_cnt_q <= flash_cnt_q + 2'd1;
                        if (flash_cnt_q == 2'd3) begin
                            flash_q <= ~flash_q;
                        end
                    end
                end
                default: begin
                    state_q <= StSync;
                end
            endcase
        end
    end

    assign fault_o       = fault_q;
    assign fault_code_o  = code_q;
    assign phase_o       = phase_q;
    assign phase_valid_o = valid_q;
    assign flash_o       = flash_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor; expectations follow
// TRAFFIC_MON_TIMING_CHECK_EN when it is defined for the build.
module tb_traffic_monitor;

`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    localparam bit TimingEn = 1'b1;
`else
    localparam bit TimingEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] east = 3'd3;
    logic [2:0] south = 3'd3;
    logic [2:0] west = 3'd3;
    logic [2:0] north = 3'd3;
    logic       clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [2:0] phase;
    logic       phase_valid;
    logic       flash;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = syncing, 1 = tracking, 2 = faulted.
    int m_mode, m_phase, m_run, m_code, m_fcyc;
    bit m_partial;

    traffic_monitor dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .east_i        (east),
        .south_i       (south),
        .west_i        (west),
        .north_i       (north),
        .clr_i         (clr),
        .fault_o       (fault),
        .fault_code_o  (fault_code),
        .phase_o       (phase),
        .phase_valid_o (phase_valid),
        .flash_o       (flash)
    );

    always #5 clk = ~clk;

    // Legal pattern for phase p as {north, west, south, east}.
    function automatic logic [11:0] pattern_of(input int p);
        logic [2:0] l [4];
        int d;
        for (int i = 0; i < 4; i++) l[i] = 3'd3;
        d = p / 2;
        if (p % 2 == 0) begin
            l[d] = 3'd1;
        end else begin
            l[d] = 3'd2;
            l[(d + 1) % 4] = 3'd2;
        end
        return {l[3], l[2], l[1], l[0]};
    endfunction

    function automatic int lookup(input logic [11:0] pat);
        for (int p = 0; p < 8; p++) begin
            if (pattern_of(p) === pat) return p;
        end
        return -1;
    endfunction

    task automatic set_phase(input int p);
        {north, west, south, east} = pattern_of(p);
    endtask

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_run = 0; m_code = 0; m_fcyc = 0; m_partial = 1'b0;
    endtask

    task automatic model_step();
        int p;
        int code;
        int need;
        p = lookup({north, west, south, east});
        if (m_mode == 2) begin
            if (clr) begin
                m_mode = 0; m_code = 0; m_fcyc = 0;
            end else begin
                m_fcyc++;
            end
        end else if (m_mode == 0) begin
            if (p >= 0) begin
                m_mode = 1; m_phase = p; m_run = 1; m_partial = 1'b1;
            end
        end else begin
            code = 0;
            need = (m_phase % 2 == 1) ? 5 : 8;
            if (p < 0) code = 1;
            else if (p != m_phase && p != (m_phase + 1) % 8) code = 2;
            else if (TimingEn && !m_partial && p != m_phase && m_run < need) code = 3;
            else if (TimingEn && !m_partial && p == m_phase && m_run == need) code = 4;
            if (code != 0) begin
                m_mode = 2; m_code = code; m_fcyc = 0;
            end else if (p != m_phase) begin
                m_phase = p; m_run = 1; m_partial = 1'b0;
            end else if (m_run < 15) begin
                m_run++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic       e_fault, e_valid, e_flash;
        logic [2:0] e_code, e_phase;
        e_fault = (m_mode == 2);
        e_valid = (m_mode == 1);
        e_flash = (m_mode == 2) && ((m_fcyc / 4) % 2 == 0);
        e_code  = 3'(m_code);
        e_phase = 3'(m_phase);
        checks++;
        assert (fault === e_fault) else begin
            errors++; $error("FAIL %s fault got %0b want %0b", tag, fault, e_fault);
        end
        checks++;
        assert (fault_code === e_code) else begin
            errors++; $error("FAIL %s fault_code got %0d want %0d", tag, fault_code, e_code);
        end
        checks++;
        assert (phase === e_phase) else begin
            errors++; $error("FAIL %s phase got %0d want %0d", tag, phase, e_phase);
        end
        checks++;
        assert (phase_valid === e_valid) else begin
            errors++; $error("FAIL %s phase_valid got %0b want %0b", tag, phase_valid, e_valid);
        end
        checks++;
        assert (flash === e_flash) else begin
            errors++; $error("FAIL %s flash got %0b want %0b", tag, flash, e_flash);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic hold(input string tag, input int p, input int n);
        set_phase(p);
        repeat (n) tick(tag);
    endtask

    task automatic pulse_clr(input string tag);
        clr = 1'b1;
        tick(tag);
        clr = 1'b0;
    endtask

    initial begin
        logic [7:0] flash_exp;
        int cur;
        int r;
        int need;

        // Reset state.
        model_reset();
        #12;
        check_all("reset");
        #1 rst_n = 1'b1;

        // Nominal cycle, two full rounds, then wrap back to E-grn.
        for (int round = 0; round < 2; round++) begin
            for (int p = 0; p < 8; p++) begin
                hold("nominal", p, (p % 2 == 1) ? 5 : 8);
            end
        end
        hold("wrap", 0, 3);

        // Illegal pattern during E-grn, then the beacon pattern.
        flash_exp = 8'b0000_1111;
        east = 3'd1; south = 3'd1; west = 3'd3; north = 3'd3;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) {north, west, south, east} = 12'($urandom);
            tick("illegal");
            checks++;
            assert (flash === flash_exp[i]) else begin
                errors++; $error("FAIL flash_seq[%0d] got %0b want %0b", i, flash, flash_exp[i]);
            end
        end
        checks++;
        assert (fault_code === 3'd1) else begin
            errors++; $error("FAIL illegal_code got %0d want 1", fault_code);
        end

        // Clear coinciding with an illegal pattern.
        east = 3'd1; south = 3'd1; west = 3'd3; north = 3'd3;
        pulse_clr("clr_illegal");
        checks++;
        assert (fault === 1'b0) else begin
            errors++; $error("FAIL clr_wins got %0b want 0", fault);
        end

        // Skipped yellow.
        hold("seq_sync", 0, 3);
        hold("seq_skip", 2, 1);
        checks++;
        assert (fault_code === 3'd2) else begin
            errors++; $error("FAIL seq_code got %0d want 2", fault_code);
        end
        pulse_clr("seq_clr");

        // Short yellow, then overstayed green.
        hold("dw_sync", 0, 3);
        hold("dw_eyel", 1, 5);
        hold("dw_sgrn", 2, 8);
        hold("dw_syel", 3, 3);
        hold("dw_short", 4, 1);
        checks++;
        assert (fault_code === (TimingEn ? 3'd3 : 3'd0)) else begin
            errors++; $error("FAIL short_code got %0d want %0d", fault_code, TimingEn ? 3 : 0);
        end
        hold("dw_wgrn", 4, 2);
        pulse_clr("dw_clr");
        hold("dw_wyel", 5, 2);
        hold("dw_ngrn", 6, 9);
        checks++;
        assert (fault_code === (TimingEn ? 3'd4 : 3'd0)) else begin
            errors++; $error("FAIL over_code got %0d want %0d", fault_code, TimingEn ? 4 : 0);
        end
        pulse_clr("dw_clr2");

        // Randomised phase lengths, skips and glitches.
        cur = 7;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                {north, west, south, east} = 12'($urandom);
                clr = 1'($urandom_range(0, 1));
                tick("rand_glitch");
                clr = 1'b0;
            end else if (r == 1) begin
                cur = (cur + 2) % 8;
                hold("rand_skip", cur, 2);
            end else begin
                cur = (cur + 1) % 8;
                need = (cur % 2 == 1) ? 5 : 8;
                hold("rand_phase", cur, $urandom_range(need - 2, need + 1));
            end
            if (m_mode == 2) begin
                set_phase(cur);
                pulse_clr("rand_clr");
            end
        end

        // Asynchronous reset mid-TRACK.
        if (m_mode == 2) pulse_clr("pre_rst_clr");
        hold("pre_rst", 0, 3);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        #1 rst_n = 1'b1;
        hold("post_rst", 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock shared with the four-way light controller.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 east, south, west, north  input  3 each  light codes (1=green, 2=yellow, 3=red, 0/4-7 invalid).
REQ-005 clr  input  1  synchronous fault clear.
REQ-006 fault  output  1  latched fault flag.
REQ-007 fault_code  output  3  0=none, 1=illegal pattern, 2=sequence, 3=short dwell, 4=overstay.
REQ-008 phase  output  3  decoded phase, 0..7 = E-grn, E-yel, S-grn, S-yel, W-grn, W-yel, N-grn, N-yel.
REQ-009 phase_valid  output  1  high while in TRACK.
REQ-010 flash  output  1  fault beacon.

Function
REQ-011 Eight legal patterns SHALL exist:
- Green phases: one direction green, other three red.
- Yellow phase d: direction d and its clockwise successor (E->S->W->N->E) yellow, other two red.
- Every other combination is illegal.
REQ-012 Inputs SHALL be sampled every rising edge; a detected fault SHALL be visible on fault/fault_code at that same edge (one-cycle latency from the offending input).
REQ-013 FSM states SHALL be SYNC, TRACK and FAULT.
REQ-014 SYNC: illegal patterns ignored; first legal sample loads phase, sets dwell=1, sets skip flag, moves to TRACK.
REQ-015 TRACK, pattern unchanged: dwell increments, saturating at 15.
REQ-016 TRACK, pattern changes: new phase SHALL equal (phase+1) mod 8; dwell reloads to 1; skip clears.
REQ-017 Required dwell SHALL be GREEN_CYCLES=8 for even phases and YELLOW_CYCLES=5 for odd phases.
REQ-018 With skip clear, a change with dwell < required SHALL raise short dwell.
REQ-019 With skip clear, an unchanged pattern sampled when dwell == required SHALL raise overstay.
REQ-020 With skip set, short-dwell and overstay checks SHALL be suppressed.
REQ-021 Fault priority SHALL be illegal > sequence > short dwell > overstay; only the highest is recorded.
REQ-022 Any fault SHALL move TRACK->FAULT and latch fault=1 and fault_code; phase holds its last valid value.
REQ-023 FAULT SHALL ignore inputs; flash toggles every 4 cycles starting at 1 on FAULT entry; flash=0 in other states.
REQ-024 clr in FAULT SHALL return to SYNC, clear fault/fault_code/flash; clr in SYNC/TRACK has no effect.
REQ-025 If clr and a new fault coincide, clr SHALL win.
REQ-026 The wrap N-yel(7) -> E-grn(0) SHALL be a legal sequence step.

Reset
REQ-027 rst low SHALL immediately force SYNC, fault=0, fault_code=0, phase=0, phase_valid=0, flash=0, dwell=0, skip=0, including mid-phase or mid-FAULT.

Configuration
REQ-028 Macro TRAFFIC_MON_TIMING_CHECK_EN defined: REQ-017..REQ-020 active.
REQ-029 Macro undefined: dwell counter and timing checks absent; fault codes 3 and 4 never produced; pattern and sequence checks unchanged.

Structure
REQ-030 Package traffic_pkg SHALL hold light codes, phase codes, fault codes, GREEN_CYCLES, YELLOW_CYCLES and the FSM state type.
REQ-031 Combinational sub-module traffic_pattern_decode SHALL map the four light inputs to {legal, phase[2:0]}.

Verification
REQ-032 Reset, then drive the nominal cycle (8 green / 5 yellow, E..N, two full rounds) -> fault stays 0; phase_valid=1 from the first sample; phase wraps 7->0.
REQ-033 During E-grn, drive east=1 and south=1 -> fault=1, fault_code=1 at that edge; flash toggles 1,1,1,1,0,0,0,0.
REQ-034 Drive E-grn then S-grn, skipping E-yel -> fault_code=2.
REQ-035 With the macro defined, after the first full phase drive S-yel for 3 cycles then W-grn -> fault_code=3; hold N-grn 9 cycles -> fault_code=4 on the 9th sample. With the macro undefined, both cases give no fault.
REQ-036 In FAULT, assert clr together with an illegal pattern -> SYNC, fault=0. Pulse rst low mid-TRACK -> all outputs 0 asynchronously.
